// File: rtl/mem_pkg.sv
// Shared definitions for the memory slave path: size codes, FSM states and the
// lane-mask / load-extension helpers (load_extend is also used by core writeback).
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size_e'(size))
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            SZ_D:    mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] align_bits(input logic [1:0] size);
        logic [2:0] bits;
        case (size_e'(size))
            SZ_B:    bits = 3'b000;
            SZ_H:    bits = 3'b001;
            SZ_W:    bits = 3'b011;
            SZ_D:    bits = 3'b111;
            default: bits = 3'b111;
        endcase
        return bits;
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                                input logic [1:0]  size,
                                                input logic        zero_ext);
        logic [63:0] ext;
        case (size_e'(size))
            SZ_B:    ext = zero_ext ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    ext = zero_ext ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    ext = zero_ext ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            SZ_D:    ext = raw;
            default: ext = raw;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/mem_slave_ctrl_if.sv
// Request/response bundle between the arbiter (master) and the memory slave.
interface mem_slave_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] PADDR;
    logic        HWRITE;
    logic [63:0] PDATA;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] HRDATA;
    logic        resp_err;

    modport master (
        output req_valid, PADDR, HWRITE, PDATA, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, HRDATA, resp_err
    );

    modport slave (
        input  req_valid, PADDR, HWRITE, PDATA, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, HRDATA, resp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the right-aligned request/response data and the
// 64-bit SRAM word: store shift + strobes, load extract + extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  st_lane,
    input  logic [1:0]  st_size,
    input  logic [63:0] st_data,
    output logic [7:0]  st_be,
    output logic [63:0] st_wdata,
    input  logic [2:0]  ld_lane,
    input  logic [1:0]  ld_size,
    input  logic        ld_zero_ext,
    input  logic [63:0] ld_raw,
    output logic [63:0] ld_data
);

    // Store side: move strobes and data up to the addressed byte lane
    always_comb begin
        st_be    = size_mask(st_size) << st_lane;
        st_wdata = st_data << {st_lane, 3'b000};
    end

    // Load side: bring the addressed lane down to bit 0, then extend
    always_comb begin
        ld_data = load_extend(ld_raw >> {ld_lane, 3'b000}, ld_size, ld_zero_ext);
    end

endmodule

// File: rtl/mem_slave_ctrl.sv
// Memory slave: runs one arbitrated request at a time against a registered
// single-port 64-bit SRAM, with optional wait states and a held response.
module mem_slave_ctrl
    import mem_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_LOG2  = 12,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    mem_slave_ctrl_if.slave       bus,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [7:0]            sram_be,
    output logic [DEPTH_LOG2-1:0] sram_addr,
    output logic [63:0]           sram_wdata,
    input  logic [63:0]           sram_rdata
);

    localparam int          OFF_W     = DEPTH_LOG2 + 3;
    localparam logic [63:0] SPAN      = 64'd1 << OFF_W;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_e             state_r;
    logic [3:0]         cnt_r;
    logic [OFF_W-1:0]   off_r;
    logic [1:0]         size_r;
    logic               write_r;
    logic [63:0]        data_r;
    logic               zext_r;
    logic               fresh_r;
    logic               resp_valid_r;
    logic               resp_err_r;
    logic [63:0]        hrdata_r;
    logic               sram_cs_r;
    logic               sram_we_r;
    logic [7:0]         sram_be_r;
    logic [DEPTH_LOG2-1:0] sram_addr_r;
    logic [63:0]        sram_wdata_r;

    logic               req_ready_s;
    logic               accept_s;
    logic [63:0]        off_full_s;
    logic               req_err_s;
    logic [OFF_W-1:0]   st_off_s;
    logic [1:0]         st_size_s;
    logic [63:0]        st_data_s;
    logic               st_write_s;
    logic [7:0]         be_s;
    logic [63:0]        wdata_s;
    logic [63:0]        load_s;

    // Request decode: acceptance, SRAM offset (mod 2^64) and legality
    always_comb begin
        req_ready_s = (state_r == ST_IDLE) || ((state_r == ST_RESP) && bus.resp_ready);
        accept_s    = bus.req_valid && req_ready_s;
        off_full_s  = bus.PADDR - BASE_ADDR;
        req_err_s   = ((bus.PADDR[2:0] & align_bits(bus.req_size)) != 3'd0)
                   || (bus.PADDR < BASE_ADDR)
                   || (off_full_s >= SPAN);
    end

    // Strobe source: live request when the access follows acceptance directly
    always_comb begin
        if (accept_s) begin
            st_off_s   = off_full_s[OFF_W-1:0];
            st_size_s  = bus.req_size;
            st_data_s  = bus.PDATA;
            st_write_s = bus.HWRITE;
        end else begin
            st_off_s   = off_r;
            st_size_s  = size_r;
            st_data_s  = data_r;
            st_write_s = write_r;
        end
    end

    mem_lane_align u_align (
        .st_lane     (st_off_s[2:0]),
        .st_size     (st_size_s),
        .st_data     (st_data_s),
        .st_be       (be_s),
        .st_wdata    (wdata_s),
        .ld_lane     (off_r[2:0]),
        .ld_size     (size_r),
        .ld_zero_ext (zext_r),
        .ld_raw      (sram_rdata),
        .ld_data     (load_s)
    );

    // Request FSM with registered SRAM strobes and response fields
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            off_r        <= '0;
            size_r       <= 2'd0;
            write_r      <= 1'b0;
            data_r       <= 64'd0;
            zext_r       <= 1'b0;
            fresh_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            hrdata_r     <= 64'd0;
            sram_cs_r    <= 1'b0;
            sram_we_r    <= 1'b0;
            sram_be_r    <= 8'h00;
            sram_addr_r  <= '0;
            sram_wdata_r <= 64'd0;
        end else begin
            sram_cs_r <= 1'b0;
            sram_we_r <= 1'b0;
            sram_be_r <= 8'h00;
            if (accept_s) begin
                off_r   <= off_full_s[OFF_W-1:0];
                size_r  <= bus.req_size;
                write_r <= bus.HWRITE;
                data_r  <= bus.PDATA;
                zext_r  <= bus.req_unsigned;
                fresh_r <= 1'b0;
                if (req_err_s) begin
                    state_r      <= ST_RESP;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b1;
                    hrdata_r     <= 64'd0;
                end else if (WAIT_CYCLES == 0) begin
                    state_r      <= ST_ACCESS;
                    resp_valid_r <= 1'b0;
                    sram_cs_r    <= 1'b1;
                    sram_we_r    <= st_write_s;
                    sram_be_r    <= st_write_s ? be_s : 8'h00;
                    sram_addr_r  <= st_off_s[OFF_W-1:3];
                    sram_wdata_r <= wdata_s;
                end else begin
                    state_r      <= ST_WAIT;
                    cnt_r        <= WAIT_INIT;
                    resp_valid_r <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_WAIT: begin
                        if (cnt_r <= 4'd1) begin
                            state_r      <= ST_ACCESS;
                            cnt_r        <= 4'd0;
                            sram_cs_r    <= 1'b1;
                            sram_we_r    <= st_write_s;
                            sram_be_r    <= st_write_s ? be_s : 8'h00;
                            sram_addr_r  <= st_off_s[OFF_W-1:3];
                            sram_wdata_r <= wdata_s;
                        end else begin
                            cnt_r <= cnt_r - 4'd1;
                        end
                    end
                    ST_ACCESS: begin
                        // Read data lands during the first RESP cycle; fresh_r routes it straight out
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        hrdata_r     <= 64'd0;
                        fresh_r      <= !write_r;
                    end
                    ST_RESP: begin
                        if (fresh_r) begin
                            hrdata_r <= load_s;
                            fresh_r  <= 1'b0;
                        end else begin
                            hrdata_r <= hrdata_r;
                        end
                        if (bus.resp_ready) begin
                            state_r      <= ST_IDLE;
                            resp_valid_r <= 1'b0;
                        end else begin
                            state_r <= ST_RESP;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.HRDATA     = fresh_r ? load_s : hrdata_r;
    assign sram_cs        = sram_cs_r;
    assign sram_we        = sram_we_r;
    assign sram_be        = sram_be_r;
    assign sram_addr      = sram_addr_r;
    assign sram_wdata     = sram_wdata_r;

endmodule

// File: doc/mem_slave_ctrl.md
Name: mem_slave_ctrl

Overview:
Downstream stage of the two-master memory arbiter. Consumes the arbitrated request (PADDR/HWRITE/PDATA plus a valid/ready handshake) and runs it against a registered single-port 64-bit SRAM. Supports programmable wait states, byte/half/word/double sizes with byte-lane strobes, load sign/zero extension, and address/alignment error responses. Returns read data with a valid/ready response handshake, so the core holds its stall until the response is consumed.

Parameters:
BASE_ADDR, 64'h0000_0000_8000_0000, byte address of SRAM word 0
DEPTH_LOG2, 12, log2 of SRAM depth in 64-bit words
WAIT_CYCLES, 0, extra idle cycles before each SRAM access (0..15)

Ports:
HCLK  input  1  clock, all state on rising edge
HRESET  input  1  synchronous active-high reset
req_valid  input  1  arbitrated request present
req_ready  output  1  request accepted when req_valid & req_ready
PADDR  input  64  byte address
HWRITE  input  1  1 = store, 0 = load
PDATA  input  64  store data, right-aligned (low bytes significant)
req_size  input  2  0=byte 1=half 2=word 3=double
req_unsigned  input  1  load zero-extends when 1, else sign-extends
resp_valid  output  1  response present
resp_ready  input  1  response consumed when resp_valid & resp_ready
HRDATA  output  64  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or out-of-range request
sram_cs  output  1  SRAM access strobe, one cycle per access
sram_we  output  1  SRAM write enable, valid with sram_cs
sram_be  output  8  byte-lane write enables
sram_addr  output  DEPTH_LOG2  word index
sram_wdata  output  64  lane-shifted store data
sram_rdata  input  DEPTH_LOG2-independent 64  SRAM read data, valid the cycle after sram_cs

Behaviour:
- Reset (HRESET=1 at an edge, any state): state=IDLE, wait counter=0, resp_valid=0, resp_err=0, HRDATA=0, sram_cs=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0. An in-flight request is dropped with no response. The SRAM is never strobed in the cycle after reset.
- States: IDLE, WAIT, ACCESS, RESP.
- req_ready = (state==IDLE) | (state==RESP & resp_ready).
- On accept, latch offset=PADDR-BASE_ADDR, size, HWRITE, PDATA, and req_unsigned.
  - Error when the low log2(bytes) address bits are nonzero, PADDR<BASE_ADDR, or offset >= 2^(DEPTH_LOG2+3).
  - Error: next state RESP with resp_err=1 and HRDATA=0. No SRAM strobe.
  - Else: next state WAIT with counter=WAIT_CYCLES, or ACCESS directly when WAIT_CYCLES=0.
- WAIT: decrement each cycle. When counter reaches 1, next state is ACCESS.
- ACCESS: one cycle.
  - sram_cs=1, sram_we=HWRITE, sram_addr=offset[DEPTH_LOG2+2:3].
  - sram_be = size mask shifted left by offset[2:0]. Masks: 0x01, 0x03, 0x0F, 0xFF.
  - sram_wdata = PDATA << (8*offset[2:0]).
  - For loads, sram_be=0. sram_cs, sram_we, and sram_be are 0 in all other states.
  - Next state RESP.
- RESP entry from ACCESS:
  - Load: HRDATA = (sram_rdata >> 8*offset[2:0]) truncated to size, then sign- or zero-extended to 64 bits.
  - Store: HRDATA=0.
  - resp_err=0. resp_valid=1 throughout RESP.
- HRDATA and resp_err hold stable while resp_valid & !resp_ready.
- RESP with resp_ready:
  - If req_valid, accept the new request the same cycle (back-to-back). It goes to WAIT or ACCESS, or to RESP if it is an error.
  - Otherwise go to IDLE.
- Latency, accept edge to resp_valid: WAIT_CYCLES+2 cycles for a legal request; 1 cycle for an error.
- Throughput with resp_ready held high: one request per WAIT_CYCLES+2 cycles.
- Inputs are sampled only on the accept cycle. Changes to PADDR or PDATA afterwards have no effect.
- Double access uses the full 64 bits. The offset address computation wraps modulo 2^64, and the range check uses an unsigned compare.

Decomposition:
- Shared package mem_pkg:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D)
  - FSM state encoding
  - size-to-mask function
  - load-extend function (reusable by the core's writeback)
- One natural sub-module, mem_lane_align: combinational store shift/strobe generation plus load extract/extend. Keeps the FSM in mem_slave_ctrl small.

Test Plan:
- Reset mid-WAIT with WAIT_CYCLES=3: assert HRESET one cycle during WAIT -> next cycle state IDLE, resp_valid=0, sram_cs never pulses, req_ready=1.
- Store byte PADDR=BASE+0x13, PDATA=0xAB, then load double from BASE+0x10 -> ACCESS shows sram_be=0x08, sram_wdata[31:24]=0xAB. Double load returns 0xAB in byte 3, preserving preloaded bytes.
- Signed half load: SRAM word0=0x0000_0000_8001_0000, PADDR=BASE+2, size=1 -> HRDATA=0xFFFF_FFFF_FFFF_8001. With req_unsigned=1 -> 0x0000_0000_0000_8001.
- Errors: word load at BASE+2; any load at BASE-8; any load at BASE+2^(DEPTH_LOG2+3) -> resp_err=1, HRDATA=0, 1-cycle latency, no sram_cs.
- Back-pressure and back-to-back, WAIT_CYCLES=0: hold resp_ready=0 for 3 cycles -> HRDATA stable. Then resp_ready=1 with req_valid=1 -> new request accepted that cycle, next sram_cs one cycle later.
- Latency sweep WAIT_CYCLES=0,1,5: sram_cs at accept+WAIT_CYCLES+1, resp_valid at accept+WAIT_CYCLES+2.
